// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fetch_pkg
// Description : Shared widths, NOP word and state encoding for the fetch
//               sequencer and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int c_inst_w = 32;
    localparam int c_addr_w = 32;
    localparam logic [c_inst_w-1:0] c_nop = 32'h0;

    // Sequencer states
    localparam int c_state_w = 3;
    localparam logic [c_state_w-1:0] c_st_idle  = 3'd0;
    localparam logic [c_state_w-1:0] c_st_fetch = 3'd1;
    localparam logic [c_state_w-1:0] c_st_drain = 3'd2;
    localparam logic [c_state_w-1:0] c_st_end   = 3'd3;
    localparam logic [c_state_w-1:0] c_st_fault = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small circular FIFO holding fetched {pc, instruction} pairs.
//               Flush empties it in one cycle and overrides push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // Storage write; contents are don't-care while empty so no reset needed
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over everything else
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Owns the PC, drives the instruction-memory address, buffers
//               fetched words and hands {pc, inst} to decode. Handles
//               redirects, misaligned-redirect faults and end of image.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned MEM_BYTES = 20,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [c_addr_w-1:0] imem_addr,
    input  logic [c_inst_w-1:0] imem_data,
    input  logic                redirect_valid,
    input  logic [c_addr_w-1:0] redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [c_inst_w-1:0] inst,
    output logic [c_addr_w-1:0] inst_pc,
    output logic                done,
    output logic                fault
);

    // End-of-image bound widened by one bit so pc values near 2^32 never wrap
    localparam logic [c_addr_w:0] c_mem_end = (c_addr_w + 1)'(MEM_BYTES);

    logic [c_state_w-1:0]         r_state;
    logic [c_state_w-1:0]         w_state_nxt;
    logic [c_addr_w-1:0]          r_pc;
    logic [c_addr_w-1:0]          w_pc_nxt;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_flush;
    logic                         w_full;
    logic                         w_empty;
    logic [c_addr_w+c_inst_w-1:0] w_head;
    logic                         w_redir_bad;
    logic                         w_redir_ok;
    logic                         w_pc_at_end;
    logic                         w_tgt_at_end;

    assign w_pc_at_end  = ({1'b0, r_pc} + 33'd3) >= c_mem_end;
    assign w_tgt_at_end = ({1'b0, redirect_pc} + 33'd3) >= c_mem_end;
    assign w_redir_bad  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_redir_ok   = redirect_valid && (redirect_pc[1:0] == 2'b00) &&
                          ((r_state == c_st_fetch) || (r_state == c_st_drain) ||
                           (r_state == c_st_end));

    assign inst_valid = !w_empty && (r_state != c_st_fault);
    assign w_pop      = inst_valid && inst_ready;

    // State and PC registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state, next PC, push and flush; faults and redirects take priority
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_flush     = (r_state == c_st_fault);
        if (r_state == c_st_fault) begin
            w_state_nxt = c_st_fault;
        end else if (w_redir_bad) begin
            w_state_nxt = c_st_fault;
            w_flush     = 1'b1;
        end else if (w_redir_ok) begin
            w_flush     = 1'b1;
            w_pc_nxt    = redirect_pc;
            w_state_nxt = w_tgt_at_end ? c_st_drain : c_st_fetch;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        w_state_nxt = c_st_fetch;
                        w_pc_nxt    = RESET_PC;
                    end
                end
                c_st_fetch: begin
                    if (w_pc_at_end) begin
                        w_state_nxt = c_st_drain;
                    end else if (!w_full || w_pop) begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
                c_st_drain: begin
                    if (w_empty) begin
                        w_state_nxt = c_st_end;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_addr_w + c_inst_w)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  ({r_pc, imem_data}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem_addr = r_pc;
    assign inst      = inst_valid ? w_head[c_inst_w-1:0] : c_nop;
    assign inst_pc   = inst_valid ? w_head[c_addr_w+c_inst_w-1:c_inst_w] : '0;
    assign done      = (r_state == c_st_end) || ((r_state == c_st_drain) && w_empty);
    assign fault     = (r_state == c_st_fault);

endmodule
`default_nettype wire
